// File: rtl/tag_request_arbiter_pkg.sv
// Package tag_arb_pkg: shared types and helpers for the tag request arbiter.
//   - requester type codes carried in INT_TAG[5:4]
//   - arbiter state encoding
//   - int_tag_of(): requester index -> {type[1:0], chnl[3:0]}
//   - clog2(): ceiling log2 for width calculations
package tag_arb_pkg;

    localparam logic [1:0] TAG_TYPE_MAIN  = 2'd0;
    localparam logic [1:0] TAG_TYPE_SG_RX = 2'd1;
    localparam logic [1:0] TAG_TYPE_SG_TX = 2'd2;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_EXCH = 1'b1
    } arb_state_e;

    // Ceiling log2; used for pointer and counter widths.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

    // Requester index is type*n_chnl + chnl; INT_TAG is {type, chnl}.
    function automatic logic [5:0] int_tag_of(input int unsigned idx, input int unsigned n_chnl);
        int unsigned tnum;
        int unsigned chnl;
        logic [1:0]  tcode;
        tnum = idx / n_chnl;
        chnl = idx % n_chnl;
        case (tnum)
            0:       tcode = TAG_TYPE_MAIN;
            1:       tcode = TAG_TYPE_SG_RX;
            default: tcode = TAG_TYPE_SG_TX;
        endcase
        return {tcode, 4'(chnl)};
    endfunction

endpackage

// File: rtl/tag_request_arbiter_if.sv
// Tag exchange bus between the RX read requesters, the arbiter and the reorder queue.
//   REQ/GNT/GNT_TAG/DONE : per-requester request, grant pulse, granted tag, credit return
//   INT_TAG/INT_TAG_VALID : internal tag offered to the reorder queue
//   EXT_TAG/EXT_TAG_VALID : external tag supplied by the reorder queue
//   BUSY                  : arbiter waiting on an exchange
// master = arbiter side, slave = requester/reorder-queue side.
interface tag_request_arbiter_if #(
    parameter int unsigned C_NUM_CHNL  = 12,
    parameter int unsigned C_TAG_WIDTH = 5
);
    localparam int unsigned R = 3 * C_NUM_CHNL;

    logic [R-1:0]           REQ;
    logic [R-1:0]           GNT;
    logic [C_TAG_WIDTH-1:0] GNT_TAG;
    logic [5:0]             INT_TAG;
    logic                   INT_TAG_VALID;
    logic [C_TAG_WIDTH-1:0] EXT_TAG;
    logic                   EXT_TAG_VALID;
    logic [R-1:0]           DONE;
    logic                   BUSY;

    modport master (
        input  REQ, EXT_TAG, EXT_TAG_VALID, DONE,
        output GNT, GNT_TAG, INT_TAG, INT_TAG_VALID, BUSY
    );

    modport slave (
        output REQ, EXT_TAG, EXT_TAG_VALID, DONE,
        input  GNT, GNT_TAG, INT_TAG, INT_TAG_VALID, BUSY
    );
endinterface

// File: rtl/tag_request_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search.
//   elig  : eligible vector
//   ptr   : last winner; search starts at (ptr+1) mod N and wraps
//   found : any bit of elig set
//   idx   : first set bit at or after (ptr+1) mod N
module rr_pick
    import tag_arb_pkg::*;
#(
    parameter int unsigned N = 36,
    localparam int unsigned W = clog2(N)
) (
    input  logic [N-1:0] elig,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [W-1:0] cand;

    // (p + k) mod N for p < N, k <= N.
    function automatic logic [W-1:0] wrap_add(input logic [W-1:0] p, input int unsigned k);
        int unsigned s;
        s = 32'(p) + k;
        if (s >= N) s = s - N;
        return W'(s);
    endfunction

    // Visit positions ptr+1 .. ptr+N; first eligible one wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = wrap_add(ptr, k);
            if (!found && elig[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/tag_request_arbiter.sv
// tag_request_arbiter: shares the reorder queue's tag-exchange port among
// 3*C_NUM_CHNL read requesters (main, sg_rx, sg_tx per channel).
//   CLK, RST : clock, synchronous active-high reset
//   bus      : tag_request_arbiter_if.master (REQ/GNT/GNT_TAG, INT_TAG/INT_TAG_VALID,
//              EXT_TAG/EXT_TAG_VALID, DONE, BUSY)
// Optional feature macro TAG_ARB_OUTSTANDING_LIMIT_EN: per-requester outstanding
// tag limit of C_MAX_OUTSTANDING, credits returned by DONE pulses.
module tag_request_arbiter
    import tag_arb_pkg::*;
#(
    parameter int unsigned C_NUM_CHNL        = 12,
    parameter int unsigned C_TAG_WIDTH       = 5,
    parameter int unsigned C_MAX_OUTSTANDING = 4
) (
    input  logic CLK,
    input  logic RST,
    tag_request_arbiter_if.master bus
);

    localparam int unsigned R     = 3 * C_NUM_CHNL;
    localparam int unsigned PTR_W = clog2(R);

    arb_state_e             state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       win_q, win_d;
    logic [R-1:0]           gnt_q, gnt_d;
    logic [C_TAG_WIDTH-1:0] gnt_tag_q, gnt_tag_d;
    logic [5:0]             int_tag_q, int_tag_d;
    logic                   int_tag_valid_q, int_tag_valid_d;
    logic                   busy_q, busy_d;

    logic [R-1:0]           elig;
    logic [R-1:0]           limit_mask;
    logic                   pick_found;
    logic [PTR_W-1:0]       pick_idx;

    // The ~gnt_q term keeps a requester out of arbitration during its own grant cycle.
    assign elig = bus.REQ & ~gnt_q & ~limit_mask;

    rr_pick #(.N(R)) u_pick (
        .elig  (elig),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Next-state and output logic.
    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        win_d           = win_q;
        gnt_d           = '0;
        gnt_tag_d       = gnt_tag_q;
        int_tag_d       = int_tag_q;
        int_tag_valid_d = 1'b0;
        unique case (state_q)
            ST_ARB: begin
                if (pick_found) begin
                    state_d         = ST_EXCH;
                    win_d           = pick_idx;
                    int_tag_d       = int_tag_of(32'(pick_idx), C_NUM_CHNL);
                    int_tag_valid_d = 1'b1;
                end
            end
            ST_EXCH: begin
                // Committed: REQ is not looked at until the exchange completes.
                int_tag_valid_d = 1'b1;
                if (int_tag_valid_q && bus.EXT_TAG_VALID) begin
                    gnt_d           = R'(1) << win_q;
                    gnt_tag_d       = bus.EXT_TAG;
                    ptr_d           = win_q;
                    state_d         = ST_ARB;
                    int_tag_valid_d = 1'b0;
                end
            end
            default: state_d = ST_ARB;
        endcase
        busy_d = (state_d == ST_EXCH);
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q         <= ST_ARB;
            ptr_q           <= PTR_W'(R - 1);
            win_q           <= '0;
            gnt_q           <= '0;
            gnt_tag_q       <= '0;
            int_tag_q       <= '0;
            int_tag_valid_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            win_q           <= win_d;
            gnt_q           <= gnt_d;
            gnt_tag_q       <= gnt_tag_d;
            int_tag_q       <= int_tag_d;
            int_tag_valid_q <= int_tag_valid_d;
            busy_q          <= busy_d;
        end
    end

`ifdef TAG_ARB_OUTSTANDING_LIMIT_EN
    localparam int unsigned CNT_W = clog2(C_MAX_OUTSTANDING + 1);

    logic [CNT_W-1:0] cnt_q [R];
    logic [CNT_W-1:0] cnt_d [R];

    // Grant takes a credit, DONE returns one; both at once cancel; no underflow.
    always_comb begin
        for (int unsigned i = 0; i < R; i++) begin
            cnt_d[i] = cnt_q[i];
            if (gnt_q[i] && !bus.DONE[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (!gnt_q[i] && bus.DONE[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
            limit_mask[i] = (cnt_q[i] == CNT_W'(C_MAX_OUTSTANDING));
        end
    end

    // Outstanding counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < R; i++) cnt_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    localparam int unsigned unused_max_outstanding = C_MAX_OUTSTANDING;
    logic unused_done;

    assign limit_mask  = '0;
    assign unused_done = ^bus.DONE;
`endif

    assign bus.GNT           = gnt_q;
    assign bus.GNT_TAG       = gnt_tag_q;
    assign bus.INT_TAG       = int_tag_q;
    assign bus.INT_TAG_VALID = int_tag_valid_q;
    assign bus.BUSY          = busy_q;

endmodule

// File: doc/tag_request_arbiter.md
# tag_request_arbiter

Shares the reorder queue's single tag-exchange port among all RX read requesters: each channel's main-data, scatter-gather-RX and scatter-gather-TX read engines. It picks one pending requester round-robin and presents its 6-bit internal tag on INT_TAG/INT_TAG_VALID. It captures the external tag returned on EXT_TAG/EXT_TAG_VALID and hands that tag back to the winner for use in its memory-read TLP. Optionally, it limits outstanding tags per requester, using the reorder queue's per-tag DONE pulses as credit returns.

## Interface
- C_NUM_CHNL, 12: channels, 1..12.
- C_TAG_WIDTH, 5: external tag width. Must match the reorder queue.
- C_MAX_OUTSTANDING, 4: per-requester outstanding-tag limit. Used only with the limit feature, ≥1.
- Requester count R = 3*C_NUM_CHNL. Index i = type*C_NUM_CHNL + chnl, where type is 0 main, 1 sg_rx, 2 sg_tx.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- REQ  in  R  level request per requester.
- GNT  out  R  one-hot, one-cycle grant pulse.
- GNT_TAG  out  C_TAG_WIDTH  external tag for the current GNT; valid only while GNT≠0.
- INT_TAG  out  6  internal tag, {type[1:0], chnl[3:0]}.
- INT_TAG_VALID  out  1  exchange request to the reorder queue.
- EXT_TAG  in  C_TAG_WIDTH  external tag from the reorder queue.
- EXT_TAG_VALID  in  1  external tag available.
- DONE  in  R  per-tag completion pulses, formed as {SG_TX_DONE, SG_RX_DONE, MAIN_DONE}.
- BUSY  out  1  high when state is EXCH.

## Operation
- States: ARB and EXCH. Reset state is ARB.
- ARB state:
  - Eligible requesters are REQ & ~GNT & ~limit_mask. The ~GNT term masks a requester during its own grant cycle.
  - If any requester is eligible, pick the first one at or after (ptr+1) mod R. Register its INT_TAG, record its index, and go to EXCH.
- EXCH state:
  - INT_TAG_VALID=1 and INT_TAG is held stable.
  - An exchange occurs in any cycle with INT_TAG_VALID & EXT_TAG_VALID. In that cycle, capture EXT_TAG, set ptr to the winner's index, and return to ARB.
  - Once in EXCH the grant is committed. REQ withdrawal is ignored and the exchange still completes.
  - No timeout: EXCH waits indefinitely for EXT_TAG_VALID.
- Grant: the cycle after an exchange, GNT[winner]=1 and GNT_TAG = captured tag. GNT is 0 in all other cycles.
- Requester contract: a requester keeps REQ high for another tag, or drops it, from the cycle after its GNT. Each GNT corresponds to exactly one TLP.
- ptr reset value is R-1, so index 0 has first priority.
- Reset mid-operation: the next cycle is ARB with INT_TAG_VALID=0, GNT=0 and counters cleared. Any tag already exchanged is abandoned; the reorder queue is reset on the same RST.

## Timing
- Reset values: GNT=0, GNT_TAG=0, INT_TAG=0, INT_TAG_VALID=0, BUSY=0.
- Cycle sequence, with EXT_TAG_VALID already high:
  - Cycle t: REQ sampled in ARB.
  - Cycle t+1: INT_TAG_VALID=1 and the exchange happens.
  - Cycle t+2: GNT pulses.
  - Cycle t+3: earliest next INT_TAG_VALID.
- Peak throughput: one tag per 2 cycles.
- Each cycle EXT_TAG_VALID stays low extends EXCH by one cycle.
- All outputs are registered. There is no combinational path from an input to an output.

## Configuration
- TAG_ARB_OUTSTANDING_LIMIT_EN defined:
  - Per-requester counter cnt[i], width clog2(C_MAX_OUTSTANDING+1), reset 0.
  - +1 on GNT[i]; −1 on DONE[i]; unchanged when both occur in the same cycle.
  - DONE[i] with cnt[i]=0 is ignored: no underflow.
  - limit_mask[i] = (cnt[i] == C_MAX_OUTSTANDING).
- Undefined: no counters, limit_mask=0, DONE is unused, and C_MAX_OUTSTANDING is ignored.

## Structure
- Package tag_arb_pkg holds:
  - type codes TAG_TYPE_MAIN=2'd0, TAG_TYPE_SG_RX=2'd1, TAG_TYPE_SG_TX=2'd2;
  - the function that maps a requester index to INT_TAG;
  - clog2.
- Sub-module rr_pick (parameter N): combinational. Takes an eligible vector and ptr; returns a found flag and the index of the first set bit after ptr, with wrap.

## Test plan
- Single request: C_NUM_CHNL=12, EXT_TAG_VALID=1, EXT_TAG=5, REQ[13] (sg_rx ch1) → INT_TAG=6'h11 at t+1; GNT[13], GNT_TAG=5 at t+2.
- Round-robin: REQ[0], REQ[5], REQ[35] held high → grant order 0, 5, 35, 0, with one GNT every 2 cycles.
- Stall: EXT_TAG_VALID low for 4 cycles in EXCH → INT_TAG stays stable, no GNT; GNT appears the cycle after EXT_TAG_VALID rises.
- Withdrawal: REQ dropped during EXCH → GNT still issued with the captured tag.
- Limit (macro on, C_MAX_OUTSTANDING=2): REQ[2] held → 2 grants, then blocked. DONE[2] pulse → third grant. DONE[2] coincident with GNT[2] → cnt unchanged.
- Reset in EXCH → next cycle INT_TAG_VALID=0, GNT=0, BUSY=0; index 0 wins first afterward.
